// File: rtl/nf10_axis_sim_rr_merge_pkg.sv
// Shared types and helpers for the AXI-Stream simulation merge blocks.
// No logic; state encodings and a constant clog2 for port sizing.
// Imported by the merge top and reusable by record/replay sim blocks.
package nf10_axis_sim_rr_merge_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } rr_state_t;

    // Index width for a requester count; never below 1 so ports stay legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nf10_axis_sim_rr_merge_prio_sel.sv
// Rotating priority selector: first set request at or after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module nf10_rr_prio_sel #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    // Walk the rotated order from the far end so the position nearest ptr wins.
    always_comb begin
        int j;
        j         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/nf10_axis_sim_rr_merge.sv
// Packet-granular round-robin merge of C_NUM_INPUTS AXI-Stream sources onto one stream.
// Zero-latency mux while a grant is held; one arbitration cycle when starting from idle.
// m_axis_tready is passed only to the granted input; others see tready=0 and simply wait.
// Optional per-input packet counters on pkt_count when NF10_AXIS_SIM_RR_PKT_COUNT_EN is defined.
module nf10_axis_sim_rr_merge
    import nf10_axis_sim_rr_merge_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_INPUTS       = 4,
    localparam int IW                = clog2(C_NUM_INPUTS)
) (
    input  logic                                          aclk,
    input  logic                                          reset,
    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_NUM_INPUTS*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]                       s_axis_tvalid,
    output logic [C_NUM_INPUTS-1:0]                       s_axis_tready,
    input  logic [C_NUM_INPUTS-1:0]                       s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          m_axis_tlast,
    output logic [IW-1:0]                                 grant_idx,
    output logic                                          busy
`ifdef NF10_AXIS_SIM_RR_PKT_COUNT_EN
    ,
    output logic [C_NUM_INPUTS*8-1:0]                     pkt_count
`endif
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    rr_state_t     state;
    rr_state_t     state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_nxt;
    logic [IW-1:0] grant_nxt;
    logic [IW-1:0] end_ptr;
    logic [IW-1:0] sel_ptr;
    logic [IW-1:0] sel_idx;
    logic          sel_vld;
    logic          pkt_end;

    // Search start for the next packet: one past the input that is finishing now.
    assign end_ptr = (grant_idx == IW'(C_NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
    // While passing, arbitrate from the post-packet pointer so the hand-off needs no bubble;
    // the finishing input is searched last and so wins only as the sole requester.
    assign sel_ptr = (state == ST_PASS) ? end_ptr : rr_ptr;
    assign busy    = (state == ST_PASS);

    nf10_rr_prio_sel #(
        .N  (C_NUM_INPUTS),
        .IW (IW)
    ) u_prio_sel (
        .req       (s_axis_tvalid),
        .ptr       (sel_ptr),
        .gnt_valid (sel_vld),
        .gnt_idx   (sel_idx)
    );

    // Next-state, grant hand-off and the granted-input mux/ready steering.
    always_comb begin
        m_axis_tdata  = s_axis_tdata[grant_idx*DW +: DW];
        m_axis_tstrb  = s_axis_tstrb[grant_idx*SW +: SW];
        m_axis_tuser  = s_axis_tuser[grant_idx*UW +: UW];
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        state_nxt     = state;
        grant_nxt     = grant_idx;
        rr_ptr_nxt    = rr_ptr;
        pkt_end       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant_nxt = sel_idx;
                    state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tvalid            = s_axis_tvalid[grant_idx];
                m_axis_tlast             = s_axis_tlast[grant_idx];
                s_axis_tready[grant_idx] = m_axis_tready;
                pkt_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;
                if (pkt_end) begin
                    rr_ptr_nxt = end_ptr;
                    if (sel_vld) begin
                        grant_nxt = sel_idx;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State, pointer and grant registers; reset drops any packet in flight.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_idx <= grant_nxt;
        end
    end

`ifdef NF10_AXIS_SIM_RR_PKT_COUNT_EN
    logic [C_NUM_INPUTS-1:0][7:0] pkt_cnt;

    // Count completed packets per source; 8-bit wrap is intentional.
    always_ff @(posedge aclk) begin
        if (reset) begin
            pkt_cnt <= '0;
        end else if (pkt_end) begin
            pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 8'd1;
        end
    end

    assign pkt_count = pkt_cnt;
`endif

endmodule

// File: tb/tb_nf10_axis_sim_rr_merge.sv
// Self-checking bench for the round-robin packet merge.
// Queue-driven sources, packet-level arbitration model, per-cycle observation at negedge.
// Downstream ready is driven constant, toggling or random depending on the scenario.
module tb_nf10_axis_sim_rr_merge;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int N  = 4;
    localparam int SW = DW / 8;
    localparam int IW = 2;

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic            aclk = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N*SW-1:0] s_axis_tstrb = '0;
    logic [N*UW-1:0] s_axis_tuser = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tready;
    logic [N-1:0]    s_axis_tlast = '0;
    logic [DW-1:0]   m_axis_tdata;
    logic [SW-1:0]   m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic [IW-1:0]   grant_idx;
    logic            busy;
`ifdef NF10_AXIS_SIM_RR_PKT_COUNT_EN
    logic [N*8-1:0]  pkt_count;
`endif

    nf10_axis_sim_rr_merge #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .C_NUM_INPUTS       (N)
    ) dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_idx     (grant_idx),
        .busy          (busy)
`ifdef NF10_AXIS_SIM_RR_PKT_COUNT_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    beat_t srcq [N][$];
    beat_t modq [N][$];
    bit    mid  [N];
    beat_t outq[$];
    int    outg[$];
    int    out_cyc[$];
    beat_t expq[$];
    int    expg[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit gap_en = 1'b0;

    logic [N-1:0]  obs_srdy;
    logic          obs_mvld;
    logic          obs_mrdy;
    logic          obs_busy;
    logic [IW-1:0] obs_grant;

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
        for (int w = 0; w < UW / 32; w++) b.u[w*32 +: 32] = $urandom;
        b.s = $urandom;
        b.l = last;
        return b;
    endfunction

    task automatic load_packet(input int src, input int len);
        for (int b = 0; b < len; b++) srcq[src].push_back(rand_beat(b == len - 1));
    endtask

    // Present each source's queue head; granted mid-packet sources may idle randomly.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_axis_tdata[i*DW +: DW] = srcq[i][0].d;
                s_axis_tstrb[i*SW +: SW] = srcq[i][0].s;
                s_axis_tuser[i*UW +: UW] = srcq[i][0].u;
                s_axis_tlast[i]          = srcq[i][0].l;
                s_axis_tvalid[i]         = !(gap_en && mid[i] && ($urandom_range(0, 3) == 0));
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tlast[i]  = 1'b0;
            end
        end
    endtask

    // One clock: observe at negedge, then retire accepted input beats after the edge.
    task automatic cycle();
        logic [N-1:0] acc;
        beat_t b;
        @(negedge aclk);
        cyc++;
        obs_srdy  = s_axis_tready;
        obs_mvld  = m_axis_tvalid;
        obs_mrdy  = m_axis_tready;
        obs_busy  = busy;
        obs_grant = grant_idx;
        if (m_axis_tvalid && m_axis_tready) begin
            b.d = m_axis_tdata;
            b.s = m_axis_tstrb;
            b.u = m_axis_tuser;
            b.l = m_axis_tlast;
            outq.push_back(b);
            outg.push_back(int'(grant_idx));
            out_cyc.push_back(cyc);
        end
        acc = s_axis_tvalid & s_axis_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && srcq[i].size() > 0) begin
                mid[i] = !srcq[i][0].l;
                void'(srcq[i].pop_front());
            end
        end
        case (rdy_mode)
            1:       m_axis_tready = !m_axis_tready;
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b1;
        endcase
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mid[i] = 1'b0;
        end
        gap_en = 1'b0;
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        reset = 1'b1;
        drive();
        repeat (2) cycle();
        reset = 1'b0;
        outq.delete();
        outg.delete();
        out_cyc.delete();
    endtask

    // Packet-level model: whole packets in turn; after each, the next source is the first
    // one with queued packets searching upward from just past the finisher, the finisher
    // itself counting as a requester (its last beat is valid) but coming last.
    task automatic build_expected();
        int g;
        int nxt;
        int ptr;
        int j;
        beat_t b;
        expq.delete();
        expg.delete();
        for (int i = 0; i < N; i++) modq[i] = srcq[i];
        g = -1;
        for (int k = N - 1; k >= 0; k--) if (modq[k].size() > 0) g = k;
        while (g >= 0) begin
            do begin
                b = modq[g].pop_front();
                expq.push_back(b);
                expg.push_back(g);
            end while (!b.l);
            ptr = (g + 1) % N;
            nxt = g;
            for (int k = N - 2; k >= 0; k--) begin
                j = (ptr + k) % N;
                if (modq[j].size() > 0) nxt = j;
            end
            if (nxt == g && modq[g].size() == 0) g = -1;
            else g = nxt;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) load_packet(i, 1);
        reset = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests++;
            if (obs_mvld !== 1'b0) begin
                fails++;
                $display("FAIL reset_mvalid cyc%0d: got %b want 0", c, obs_mvld);
            end
            tests++;
            if (obs_srdy !== '0) begin
                fails++;
                $display("FAIL reset_tready cyc%0d: got %b want 0000", c, obs_srdy);
            end
            tests++;
            if (obs_busy !== 1'b0 || obs_grant !== '0) begin
                fails++;
                $display("FAIL reset_busy_grant cyc%0d: got busy %b grant %0d want 0/0",
                         c, obs_busy, obs_grant);
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int p = 0; p < 2; p++) for (int i = 0; i < N; i++) load_packet(i, 3);
        build_expected();
        drive();
        for (int c = 0; c < 200 && outq.size() < expq.size(); c++) cycle();
        tests++;
        if (outq.size() != expq.size()) begin
            fails++;
            $display("FAIL fair_count: got %0d beats want %0d", outq.size(), expq.size());
        end
        for (int k = 0; k < outq.size() && k < expq.size(); k++) begin
            tests++;
            if (outq[k].d !== expq[k].d || outq[k].s !== expq[k].s || outq[k].u !== expq[k].u ||
                outq[k].l !== expq[k].l || outg[k] != expg[k]) begin
                fails++;
                $display("FAIL fair_beat%0d: got src %0d last %b data %h want src %0d last %b data %h",
                         k, outg[k], outq[k].l, outq[k].d, expg[k], expq[k].l, expq[k].d);
            end
        end
        for (int p = 0; p < 8 && p * 3 < outg.size(); p++) begin
            tests++;
            if (outg[p*3] != p % N) begin
                fails++;
                $display("FAIL fair_order pkt%0d: got %0d want %0d", p, outg[p*3], p % N);
            end
        end
        tests++;
        if (out_cyc.size() != 24 || out_cyc[23] - out_cyc[0] != 23) begin
            fails++;
            $display("FAIL fair_no_bubble: got %0d beats spanning %0d cycles want 24 in 24",
                     out_cyc.size(), (out_cyc.size() > 0) ? out_cyc[$] - out_cyc[0] + 1 : 0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_mode = 1;
        load_packet(2, 5);
        build_expected();
        drive();
        for (int c = 0; c < 40 && outq.size() < expq.size(); c++) begin
            cycle();
            tests++;
            if ((obs_srdy & 4'b1011) !== 4'b0000 || (obs_busy && obs_srdy[2] !== obs_mrdy)) begin
                fails++;
                $display("FAIL bp_tready cyc%0d: got tready %b busy %b with m_tready %b",
                         c, obs_srdy, obs_busy, obs_mrdy);
            end
        end
        tests++;
        if (outq.size() != 5) begin
            fails++;
            $display("FAIL bp_count: got %0d beats want 5", outq.size());
        end
        for (int k = 0; k < outq.size() && k < expq.size(); k++) begin
            tests++;
            if (outq[k].d !== expq[k].d || outq[k].l !== expq[k].l || outg[k] != 2) begin
                fails++;
                $display("FAIL bp_beat%0d: got src %0d last %b data %h want src 2 last %b data %h",
                         k, outg[k], outq[k].l, outq[k].d, expq[k].l, expq[k].d);
            end
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        for (int p = 0; p < 3; p++) load_packet(1, 1);
        build_expected();
        drive();
        for (int c = 0; c < 20 && outq.size() < 3; c++) cycle();
        tests++;
        if (outg.size() != 3 || outg[0] != 1 || outg[1] != 1 || outg[2] != 1 ||
            out_cyc[2] - out_cyc[0] != 2) begin
            fails++;
            $display("FAIL sole_grants: got %0d packets (want 3 back-to-back from input 1)",
                     outg.size());
        end
        for (int c = 0; c < 2; c++) begin
            cycle();
            tests++;
            if (obs_busy !== 1'b1 || obs_grant !== 2'd1) begin
                fails++;
                $display("FAIL sole_hold cyc%0d: got busy %b grant %0d want 1/1",
                         c, obs_busy, obs_grant);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        beat_t b0;
        do_reset();
        load_packet(1, 1);
        load_packet(3, 4);
        drive();
        for (int c = 0; c < 20 && outq.size() < 2; c++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        load_packet(0, 1);
        b0 = srcq[0][0];
        drive();
        cycle();
        tests++;
        if (obs_busy !== 1'b0 || obs_mvld !== 1'b0 || obs_grant !== '0) begin
            fails++;
            $display("FAIL rstmid_idle: got busy %b mvalid %b grant %0d want 0/0/0",
                     obs_busy, obs_mvld, obs_grant);
        end
        tests++;
        if (outq.size() != 3) begin
            fails++;
            $display("FAIL rstmid_truncated: got %0d beats want 3", outq.size());
        end
        cycle();
        tests++;
        if (obs_mvld !== 1'b1 || obs_grant !== '0 || outq.size() != 4 || outq[$].d !== b0.d) begin
            fails++;
            $display("FAIL rstmid_regrant: got mvalid %b grant %0d beats %0d want 1/0/4",
                     obs_mvld, obs_grant, outq.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            do_reset();
            gap_en = 1'b1;
            rdy_mode = 2;
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) load_packet(i, $urandom_range(1, 4));
            end
            load_packet($urandom_range(0, N - 1), $urandom_range(1, 4));
            build_expected();
            drive();
            for (int c = 0; c < 2000 && outq.size() < expq.size(); c++) cycle();
            tests++;
            if (outq.size() != expq.size()) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d beats want %0d", r, outq.size(), expq.size());
            end
            for (int k = 0; k < outq.size() && k < expq.size(); k++) begin
                tests++;
                if (outq[k].d !== expq[k].d || outq[k].s !== expq[k].s ||
                    outq[k].u !== expq[k].u || outq[k].l !== expq[k].l || outg[k] != expg[k]) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d: got src %0d last %b data %h want src %0d last %b data %h",
                             r, k, outg[k], outq[k].l, outq[k].d, expg[k], expq[k].l, expq[k].d);
                end
            end
        end
    endtask

`ifdef NF10_AXIS_SIM_RR_PKT_COUNT_EN
    task automatic test_pkt_count();
        do_reset();
        for (int p = 0; p < 257; p++) load_packet(0, 1);
        drive();
        for (int c = 0; c < 600 && outq.size() < 257; c++) cycle();
        tests++;
        if (pkt_count[7:0] !== 8'd1 || pkt_count[N*8-1:8] !== '0) begin
            fails++;
            $display("FAIL pkt_count: got %h want 00000001", pkt_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_sole_requester();
        test_reset_mid_packet();
        test_random();
`ifdef NF10_AXIS_SIM_RR_PKT_COUNT_EN
        test_pkt_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
